stepper_phase_seq: RTL and testbench

- Parametrised successor to the fixed 4-state free-running stepper phase driver.
- Converts step/direction commands, or an internal programmable step-rate timer, into the four coil drive lines of a bipolar stepper.
- Supports wave, full (two-phase-on) and half-step modes, plus coil enable/freewheel.
- Tracks a wrapping signed position count; sits between motion control logic and the H-bridge pins.

---
 rtl/stepper_phase_seq.sv | 112 +++++++++++
 tb/tb_stepper_phase_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_seq.sv
`default_nettype none
// stepper_phase_seq -- step/dir or timer-driven bipolar stepper phase sequencer (wave/full/half).
// Rev 1.0

module stepper_phase_seq #(
   parameter int POS_W = 32,
   parameter int DIV_W = 24
) (
   input  logic             CLK,
   input  logic             resetn,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             step,
   input  logic             auto_en,
   input  logic [DIV_W-1:0] step_period,
   output logic             phase_a1,
   output logic             phase_a2,
   output logic             phase_b1,
   output logic             phase_b2,
   output logic [POS_W-1:0] position,
   output logic             step_done
);

   localparam logic [1:0] MODE_WAVE = 2'd0;
   localparam logic [1:0] MODE_HALF = 2'd2;
   localparam logic [2:0] IDX_RESET = 3'd1;

   logic [2:0]       idx;
   logic [2:0]       idx_delta;
   logic [2:0]       idx_next;
   logic [DIV_W-1:0] timer;
   logic [DIV_W-1:0] period_m1;
   logic             timer_run;
   logic             timer_tick;
   logic             step_acc;
   logic [3:0]       coil_next;

   // Half-step table, bit order {a1, a2, b1, b2}
   function automatic logic [3:0] coil_pattern(input logic [2:0] i);
      logic [3:0] p;
      case (i)
         3'd0:    p = 4'b1000;
         3'd1:    p = 4'b1010;
         3'd2:    p = 4'b0010;
         3'd3:    p = 4'b0110;
         3'd4:    p = 4'b0100;
         3'd5:    p = 4'b0101;
         3'd6:    p = 4'b0001;
         default: p = 4'b1001;
      endcase
      return p;
   endfunction

   // Compare with >= so a shortened period takes effect without waiting for a wrap
   assign timer_run  = auto_en & enable & (step_period != '0);
   assign period_m1  = step_period - DIV_W'(1);
   assign timer_tick = timer_run & (timer >= period_m1);

   assign step_acc = enable & (auto_en ? timer_tick : step);

   // Full mode lands on odd (two-coil) indices, wave mode on even (one-coil) indices
   always_comb begin
      idx_delta = 3'd1;
      case (mode)
         MODE_HALF: idx_delta = 3'd1;
         MODE_WAVE: idx_delta = idx[0] ? 3'd1 : 3'd2;
         default:   idx_delta = idx[0] ? 3'd2 : 3'd1;
      endcase
   end

   always_comb begin
      idx_next = idx;
      if (step_acc) begin
         idx_next = dir ? (idx + idx_delta) : (idx - idx_delta);
      end
   end

   assign coil_next = enable ? coil_pattern(idx_next) : 4'b0000;

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         timer <= '0;
      end else if (!timer_run || timer_tick) begin
         timer <= '0;
      end else begin
         timer <= timer + DIV_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         idx       <= IDX_RESET;
         position  <= '0;
         step_done <= 1'b0;
         phase_a1  <= 1'b0;
         phase_a2  <= 1'b0;
         phase_b1  <= 1'b0;
         phase_b2  <= 1'b0;
      end else begin
         idx       <= idx_next;
         step_done <= step_acc;
         {phase_a1, phase_a2, phase_b1, phase_b2} <= coil_next;
         if (step_acc) begin
            position <= dir ? (position + POS_W'(1)) : (position - POS_W'(1));
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stepper_phase_seq.sv
`default_nettype none
// tb_stepper_phase_seq -- directed checks of stepper_phase_seq with hand-computed expectations.
// Rev 1.0

module tb_stepper_phase_seq;

   logic        CLK = 1'b0;
   logic        resetn;
   logic        enable;
   logic [1:0]  mode;
   logic        dir;
   logic        step;
   logic        auto_en;
   logic [23:0] step_period;

   logic        a1, a2, b1, b2;
   logic [31:0] position;
   logic        step_done;
   logic [3:0]  coils;

   logic        a1_4, a2_4, b1_4, b2_4;
   logic [3:0]  position4;
   logic        step_done4;

   int vectors     = 0;
   int miscompares = 0;
   int pulses;

   logic [3:0] exp_full [4] = '{4'b0110, 4'b0101, 4'b1001, 4'b1010};
   logic [3:0] exp_half [8] = '{4'b1000, 4'b1001, 4'b0001, 4'b0101,
                                4'b0100, 4'b0110, 4'b0010, 4'b1010};

   assign coils = {a1, a2, b1, b2};

   always #5 CLK = ~CLK;

   stepper_phase_seq #(.POS_W(32), .DIV_W(24)) dut (
      .CLK(CLK), .resetn(resetn), .enable(enable), .mode(mode), .dir(dir),
      .step(step), .auto_en(auto_en), .step_period(step_period),
      .phase_a1(a1), .phase_a2(a2), .phase_b1(b1), .phase_b2(b2),
      .position(position), .step_done(step_done)
   );

   stepper_phase_seq #(.POS_W(4), .DIV_W(24)) dut4 (
      .CLK(CLK), .resetn(resetn), .enable(enable), .mode(mode), .dir(dir),
      .step(step), .auto_en(auto_en), .step_period(step_period),
      .phase_a1(a1_4), .phase_a2(a2_4), .phase_b1(b1_4), .phase_b2(b2_4),
      .position(position4), .step_done(step_done4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0; enable = 1'b0; mode = 2'd1; dir = 1'b1;
      step = 1'b0; auto_en = 1'b0; step_period = 24'd0;
      #22;
      check("rst_coils", 32'(coils), 32'h0);
      check("rst_pos", position, 32'h0);
      check("rst_done", 32'(step_done), 32'h0);
      resetn = 1'b1;

      // Full-step forward, spaced strobes
      enable = 1'b1;
      cyc();
      check("en_coils", 32'(coils), 32'hA);
      for (int i = 0; i < 4; i++) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         check("full_coils", 32'(coils), 32'(exp_full[i]));
         check("full_done", 32'(step_done), 32'h1);
         cyc();
         check("full_done_low", 32'(step_done), 32'h0);
         cyc();
      end
      check("full_pos", position, 32'd4);

      // Half-step reverse, back-to-back strobes
      mode = 2'd2; dir = 1'b0; step = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("half_coils", 32'(coils), 32'(exp_half[i]));
         check("half_done", 32'(step_done), 32'h1);
      end
      step = 1'b0;
      cyc();
      check("half_done_low", 32'(step_done), 32'h0);
      check("half_pos", position, 32'hFFFF_FFFC);
      check("half_pos4", 32'(position4), 32'hC);

      // Wave forward from odd index snaps to even
      mode = 2'd0; dir = 1'b1; step = 1'b1;
      cyc();
      step = 1'b0;
      check("wave_coils", 32'(coils), 32'h2);
      check("wave_pos", position, 32'hFFFF_FFFD);

      // Auto stepping, external step ignored
      auto_en = 1'b1; step_period = 24'd5; step = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         check("auto_pulse", 32'(step_done), (k % 5 == 0) ? 32'h1 : 32'h0);
         if (step_done) pulses++;
      end
      step = 1'b0;
      check("auto_count", 32'(pulses), 32'd4);
      check("auto_pos", position, 32'd1);
      check("auto_coils", 32'(coils), 32'h2);

      // Shortening period below current count fires at once
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("pchg_wait", 32'(step_done), 32'h0);
      end
      step_period = 24'd2;
      cyc();
      check("pchg_fire", 32'(step_done), 32'h1);
      cyc();
      check("pchg_gap", 32'(step_done), 32'h0);
      cyc();
      check("pchg_fire2", 32'(step_done), 32'h1);
      check("pchg_coils", 32'(coils), 32'h1);

      // Period 1: step every cycle
      step_period = 24'd1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("p1_done", 32'(step_done), 32'h1);
      end
      check("p1_pos", position, 32'd8);
      check("p1_coils", 32'(coils), 32'h8);

      // Period 0: no steps
      step_period = 24'd0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (step_done) pulses++;
      end
      check("p0_count", 32'(pulses), 32'd0);
      check("p0_pos", position, 32'd8);

      // Enable drop mid auto-run
      step_period = 24'd5;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         check("ena_run", 32'(step_done), (k == 5) ? 32'h1 : 32'h0);
      end
      check("ena_run_pos", position, 32'd9);
      enable = 1'b0;
      cyc();
      check("dis_coils", 32'(coils), 32'h0);
      step = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         check("dis_done", 32'(step_done), 32'h0);
      end
      check("dis_pos", position, 32'd9);
      step = 1'b0;
      enable = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         if (k == 1) check("reen_coils", 32'(coils), 32'h2);
         check("reen_done", 32'(step_done), (k == 5) ? 32'h1 : 32'h0);
      end
      check("reen_step_coils", 32'(coils), 32'h4);
      check("reen_pos", position, 32'd10);

      // Position wrap, 4-bit and 32-bit
      auto_en = 1'b0; step_period = 24'd0;
      #2;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      mode = 2'd2; dir = 1'b1; step = 1'b1;
      for (int k = 0; k < 17; k++) cyc();
      step = 1'b0;
      check("wrap_fwd_pos4", 32'(position4), 32'd1);
      check("wrap_fwd_pos", position, 32'd17);
      check("wrap_fwd_coils", 32'(coils), 32'h2);
      dir = 1'b0; step = 1'b1;
      for (int k = 0; k < 2; k++) cyc();
      check("wrap_rev_pos4", 32'(position4), 32'd15);
      check("wrap_rev_pos", position, 32'd15);
      for (int k = 0; k < 16; k++) cyc();
      step = 1'b0;
      check("wrap_rev32_pos", position, 32'hFFFF_FFFF);
      check("wrap_rev32_pos4", 32'(position4), 32'd15);
      check("wrap_rev_coils", 32'(coils), 32'h8);

      // Asynchronous reset mid-run
      auto_en = 1'b1; step_period = 24'd1;
      for (int k = 0; k < 3; k++) cyc();
      #3;
      resetn = 1'b0;
      #1;
      check("arst_coils", 32'(coils), 32'h0);
      check("arst_pos", position, 32'h0);
      check("arst_done", 32'(step_done), 32'h0);
      check("arst_pos4", 32'(position4), 32'h0);
      auto_en = 1'b0; step_period = 24'd0;
      #2;
      resetn = 1'b1;
      cyc();
      check("post_rst_coils", 32'(coils), 32'hA);
      check("post_rst_pos", position, 32'h0);
      check("post_rst_done", 32'(step_done), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
